// File: rtl/prefix_encoder.sv
// Serialises one instruction descriptor into an x86 byte stream:
// prefixes, 0F escape, opcode, then up to TAIL_MAX tail bytes.
module prefix_encoder #(
  parameter int TAIL_MAX = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs_d_b,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_rep,
  input  logic                  req_lock,
  input  logic [2:0]            req_seg,
  input  logic                  req_op32,
  input  logic                  req_addr32,
  input  logic                  req_2byte,
  input  logic [7:0]            req_opcode,
  input  logic [8*TAIL_MAX-1:0] req_tail,
  input  logic [2:0]            req_tail_len,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_byte,
  output logic                  out_last,
  output logic [3:0]            prefix_count
);

  typedef enum logic [1:0] {
    IDLE,
    PREFIX,
    OPCODE,
    TAIL
  } state_t;

  localparam logic [2:0] TMAX = 3'(TAIL_MAX);

  state_t                  state_q, state_d;
  logic [5:0]              mask_q, mask_d;
  logic [7:0]              rep_q, rep_d;
  logic [7:0]              seg_q, seg_d;
  logic [7:0]              opc_q, opc_d;
  logic [8*TAIL_MAX-1:0]   tail_q, tail_d;
  logic [2:0]              len_q, len_d;
  logic                    valid_q, valid_d;
  logic [7:0]              byte_q, byte_d;
  logic                    last_q, last_d;
  logic [3:0]              pcnt_q, pcnt_d;

  logic [5:0] acc_mask;
  logic [7:0] acc_rep;
  logic [7:0] acc_seg;
  logic [2:0] acc_len;
  logic [5:0] mask_nx;
  logic       xfer;

  // Mask bit order is the emission order: F0, rep, seg, 66, 67, 0F.
  function automatic logic [7:0] pfx_byte(
    input logic [5:0] m,
    input logic [7:0] rep_b,
    input logic [7:0] seg_b
  );
    logic [7:0] b;
    b = 8'h0F;
    if (m[0])      b = 8'hF0;
    else if (m[1]) b = rep_b;
    else if (m[2]) b = seg_b;
    else if (m[3]) b = 8'h66;
    else if (m[4]) b = 8'h67;
    return b;
  endfunction

  always_comb begin
    acc_seg = 8'h00;
    case (req_seg)
      3'd0:    acc_seg = 8'h26;
      3'd1:    acc_seg = 8'h2E;
      3'd2:    acc_seg = 8'h36;
      3'd3:    acc_seg = 8'h3E;
      3'd4:    acc_seg = 8'h64;
      3'd5:    acc_seg = 8'h65;
      default: acc_seg = 8'h00;
    endcase
    acc_rep  = (req_rep == 2'd1) ? 8'hF2 : 8'hF3;
    acc_len  = (req_tail_len > TMAX) ? TMAX : req_tail_len;
    acc_mask = {req_2byte,
                req_addr32 ^ cs_d_b,
                req_op32 ^ cs_d_b,
                req_seg < 3'd6,
                req_rep == 2'd1 || req_rep == 2'd2,
                req_lock};
  end

  assign mask_nx = mask_q & (mask_q - 6'd1);
  assign xfer    = valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    rep_d   = rep_q;
    seg_d   = seg_q;
    opc_d   = opc_q;
    tail_d  = tail_q;
    len_d   = len_q;
    valid_d = valid_q;
    byte_d  = byte_q;
    last_d  = last_q;
    pcnt_d  = pcnt_q;
    if (flush) begin
      state_d = IDLE;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          mask_d  = acc_mask;
          rep_d   = acc_rep;
          seg_d   = acc_seg;
          opc_d   = req_opcode;
          tail_d  = req_tail;
          len_d   = acc_len;
          pcnt_d  = 4'd0;
          valid_d = 1'b1;
          if (acc_mask != 6'd0) begin
            state_d = PREFIX;
            byte_d  = pfx_byte(acc_mask, acc_rep, acc_seg);
            last_d  = 1'b0;
          end else begin
            state_d = OPCODE;
            byte_d  = req_opcode;
            last_d  = (acc_len == 3'd0);
          end
        end
        PREFIX: if (xfer) begin
          mask_d = mask_nx;
          pcnt_d = pcnt_q + 4'd1;
          if (mask_nx != 6'd0) begin
            byte_d = pfx_byte(mask_nx, rep_q, seg_q);
          end else begin
            state_d = OPCODE;
            byte_d  = opc_q;
            last_d  = (len_q == 3'd0);
          end
        end
        OPCODE: if (xfer) begin
          if (len_q != 3'd0) begin
            state_d = TAIL;
            byte_d  = tail_q[7:0];
            tail_d  = tail_q >> 8;
            len_d   = len_q - 3'd1;
            last_d  = (len_q == 3'd1);
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end
        end
        TAIL: if (xfer) begin
          // len_q counts tail bytes not yet loaded into out_byte.
          if (len_q != 3'd0) begin
            byte_d = tail_q[7:0];
            tail_d = tail_q >> 8;
            len_d  = len_q - 3'd1;
            last_d = (len_q == 3'd1);
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
      rep_q   <= '0;
      seg_q   <= '0;
      opc_q   <= '0;
      tail_q  <= '0;
      len_q   <= '0;
      valid_q <= 1'b0;
      byte_q  <= '0;
      last_q  <= 1'b0;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      rep_q   <= rep_d;
      seg_q   <= seg_d;
      opc_q   <= opc_d;
      tail_q  <= tail_d;
      len_q   <= len_d;
      valid_q <= valid_d;
      byte_q  <= byte_d;
      last_q  <= last_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign out_valid    = valid_q;
  assign out_byte     = byte_q;
  assign out_last     = last_q;
  assign prefix_count = pcnt_q;

endmodule

// File: tb/tb_prefix_encoder.sv
// Directed bench for prefix_encoder: a byte-queue model checked every
// cycle, plus literal stream expectations for each directed case.
module tb_prefix_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs_d_b = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_rep = '0;
  logic        req_lock = 1'b0;
  logic [2:0]  req_seg = 3'd7;
  logic        req_op32 = 1'b0;
  logic        req_addr32 = 1'b0;
  logic        req_2byte = 1'b0;
  logic [7:0]  req_opcode = '0;
  logic [47:0] req_tail = '0;
  logic [2:0]  req_tail_len = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_byte;
  logic        out_last;
  logic [3:0]  prefix_count;

  int nchk = 0;
  int nerr = 0;

  logic [7:0] exp_q[$];
  bit         pfx_q[$];
  logic [7:0] got_q[$];
  int         pfx_sent = 0;

  prefix_encoder #(.TAIL_MAX(6)) dut (
    .clk(clk), .rst(rst), .cs_d_b(cs_d_b), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rep(req_rep), .req_lock(req_lock), .req_seg(req_seg),
    .req_op32(req_op32), .req_addr32(req_addr32),
    .req_2byte(req_2byte), .req_opcode(req_opcode),
    .req_tail(req_tail), .req_tail_len(req_tail_len),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_byte(out_byte), .out_last(out_last),
    .prefix_count(prefix_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] expv);
    nchk++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Expected instruction bytes straight from the encoding rules.
  task automatic model_push();
    int n;
    logic [7:0] segtab [6];
    segtab = '{8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65};
    if (req_lock) begin exp_q.push_back(8'hF0); pfx_q.push_back(1); end
    if (req_rep == 1) begin exp_q.push_back(8'hF2); pfx_q.push_back(1); end
    if (req_rep == 2) begin exp_q.push_back(8'hF3); pfx_q.push_back(1); end
    if (req_seg < 6) begin
      exp_q.push_back(segtab[req_seg]); pfx_q.push_back(1);
    end
    if (req_op32 != cs_d_b) begin exp_q.push_back(8'h66); pfx_q.push_back(1); end
    if (req_addr32 != cs_d_b) begin exp_q.push_back(8'h67); pfx_q.push_back(1); end
    if (req_2byte) begin exp_q.push_back(8'h0F); pfx_q.push_back(1); end
    exp_q.push_back(req_opcode); pfx_q.push_back(0);
    n = (req_tail_len > 6) ? 6 : int'(req_tail_len);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(req_tail[8*i +: 8]); pfx_q.push_back(0);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      pfx_q.delete();
    end else begin
      chk("req_ready", {31'd0, req_ready}, {31'd0, exp_q.size() == 0});
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
      if (exp_q.size() != 0 && out_valid) begin
        chk("out_byte", {24'd0, out_byte}, {24'd0, exp_q[0]});
        chk("out_last", {31'd0, out_last}, {31'd0, exp_q.size() == 1});
        chk("prefix_count", {28'd0, prefix_count}, pfx_sent);
      end
      if (flush) begin
        exp_q.delete();
        pfx_q.delete();
      end else if (out_valid && out_ready && exp_q.size() != 0) begin
        got_q.push_back(out_byte);
        if (pfx_q[0]) pfx_sent++;
        void'(exp_q.pop_front());
        void'(pfx_q.pop_front());
      end else if (req_valid && req_ready) begin
        pfx_sent = 0;
        model_push();
      end
    end
  end

  task automatic send(input logic [1:0] rep, input logic lk,
                      input logic [2:0] sg, input logic o32,
                      input logic a32, input logic b2,
                      input logic [7:0] opc, input logic [47:0] tl,
                      input logic [2:0] ln);
    int n;
    n = 0;
    while (!req_ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("ready_timeout", {31'd0, req_ready}, 32'd1);
    req_rep = rep; req_lock = lk; req_seg = sg;
    req_op32 = o32; req_addr32 = a32; req_2byte = b2;
    req_opcode = opc; req_tail = tl; req_tail_len = ln;
    got_q.delete();
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit done;
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      if (!out_valid && exp_q.size() == 0) done = 1;
      else begin @(posedge clk); #1; end
    end
    chk("done_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic wait_byte(input logic [7:0] b);
    bit hit;
    hit = 0;
    for (int i = 0; i < 30 && !hit; i++) begin
      if (out_valid && out_byte == b) hit = 1;
      else begin @(posedge clk); #1; end
    end
    chk("byte_timeout", {31'd0, hit}, 32'd1);
  endtask

  task automatic chk_stream(input string nm, input logic [7:0] e[$]);
    chk({nm, "_len"}, got_q.size(), e.size());
    for (int i = 0; i < e.size(); i++)
      chk(nm, (i < got_q.size()) ? {24'd0, got_q[i]} : 32'hFFFF,
          {24'd0, e[i]});
  endtask

  logic [7:0] s[$];

  initial begin
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_byte", {24'd0, out_byte}, 32'd0);
    chk("rst_last", {31'd0, out_last}, 32'd0);
    chk("rst_pcnt", {28'd0, prefix_count}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    cs_d_b = 0;
    send(2, 0, 3, 1, 0, 0, 8'hA5, 48'h0, 0);
    wait_done();
    s = '{8'hF3, 8'h3E, 8'h66, 8'hA5};
    chk_stream("case1", s);
    chk("case1_pcnt", {28'd0, prefix_count}, 32'd3);

    cs_d_b = 1;
    send(0, 0, 7, 1, 1, 0, 8'h89, 48'hD8, 1);
    wait_done();
    s = '{8'h89, 8'hD8};
    chk_stream("case2", s);
    chk("case2_pcnt", {28'd0, prefix_count}, 32'd0);

    cs_d_b = 1;
    send(0, 1, 7, 0, 0, 1, 8'hB1, 48'h3412, 2);
    cs_d_b = 0;
    wait_done();
    s = '{8'hF0, 8'h66, 8'h67, 8'h0F, 8'hB1, 8'h12, 8'h34};
    chk_stream("case3", s);
    chk("case3_pcnt", {28'd0, prefix_count}, 32'd4);

    cs_d_b = 0;
    send(2, 0, 3, 1, 0, 0, 8'hA5, 48'h0, 0);
    wait_byte(8'h3E);
    out_ready = 0;
    repeat (3) @(posedge clk);
    #1 out_ready = 1;
    wait_done();
    s = '{8'hF3, 8'h3E, 8'h66, 8'hA5};
    chk_stream("bp", s);

    send(2, 0, 3, 1, 0, 0, 8'hA5, 48'h0, 0);
    wait_byte(8'h66);
    out_ready = 0;
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_last", {31'd0, out_last}, 32'd0);
    chk("flush_ready", {31'd0, req_ready}, 32'd1);
    out_ready = 1;
    send(1, 0, 0, 0, 0, 0, 8'h90, 48'h0, 0);
    wait_done();
    s = '{8'hF2, 8'h26, 8'h90};
    chk_stream("post_flush", s);

    req_seg = 7; req_rep = 0; req_opcode = 8'h55;
    flush = 1; req_valid = 1;
    @(posedge clk); #1;
    flush = 0; req_valid = 0;
    chk("flush_idle_ready", {31'd0, req_ready}, 32'd1);
    chk("flush_idle_valid", {31'd0, out_valid}, 32'd0);

    send(3, 0, 6, 0, 0, 0, 8'h90, 48'h060504030201, 7);
    wait_done();
    s = '{8'h90, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    chk_stream("clamp", s);
    chk("clamp_pcnt", {28'd0, prefix_count}, 32'd0);

    cs_d_b = 1;
    send(0, 1, 7, 0, 0, 1, 8'hB1, 48'h3412, 2);
    @(posedge clk);
    #3 rst = 1;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_byte", {24'd0, out_byte}, 32'd0);
    chk("arst_last", {31'd0, out_last}, 32'd0);
    chk("arst_pcnt", {28'd0, prefix_count}, 32'd0);
    chk("arst_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1 rst = 0;
    send(0, 0, 7, 1, 1, 0, 8'h89, 48'hD8, 1);
    wait_done();
    s = '{8'h89, 8'hD8};
    chk_stream("post_rst", s);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
